debug_led_monitor: RTL
======================

Name: debug_led_monitor

Overview:
Parametrised successor to the board debug-LED mapper. It takes N_CH packed debug channels, for example {sel, seg[6:0]} from several 7-seg drivers, and drives the board LED bank. Display modes are live, hold, sticky and pulse-stretch, plus an auto-scan across channels, so slow or short debug events are visible to the eye. It sits at top level between the debug taps and the LD pins.

Parameters:
- N_CH, 4, number of input channels (≥1)
- W, 8, bits per channel and LED count
- STRETCH_CYC, 10_000_000, cycles an LED is held on after a high sample in STRETCH mode (≥1)
- SCAN_CYC, 100_000_000, dwell cycles per channel in SCAN mode (≥1)
- CW (localparam), max(1,$clog2(N_CH)), channel index width

Ports:
- clk, in, 1, system clock
- rst, in, 1, reset; asynchronous, active-high
- ch_data, in, N_CH*W, channel k occupies bits [k*W +: W]
- mode, in, 3, display mode (encoding in package)
- ch_sel, in, CW, channel selected in non-scan modes
- clear, in, 1, single-cycle clear of the sticky accumulator
- LD, out, W, LED drive, registered
- ld_ch, out, CW, channel currently displayed, registered

Behaviour:
- Reset: LD=0, ld_ch=0, capture reg=0, sticky acc=0, hold reg=0, all stretch counters=0, scan counter=0, scan index=0, previous-mode reg=LIVE.
- Pipeline: ch_data is registered into cap every cycle. Output stage registers LD/ld_ch from cap. Latency from ch_data to LD is 2 cycles in LIVE/SCAN.
- Effective channel: ch_sel in non-scan modes. If ch_sel ≥ N_CH, use channel 0.
- Mode and channel changes take effect on the next clock edge.
- LIVE (0): LD <= cap[ch]; ld_ch <= ch.
- HOLD (1): on the first cycle in HOLD, hold_reg <= cap[ch]. Afterwards LD = hold_reg, unchanged by data or ch_sel. ld_ch shows the channel frozen at entry. Re-entering HOLD takes a fresh snapshot.
- STICKY (2): acc <= acc | cap[ch]; LD = acc.
  - acc is cleared to 0 on entry to STICKY, on a ch_sel change while in STICKY, and on clear.
  - If clear and a high sample occur in the same cycle, clear wins: acc=0 that cycle, and ORing resumes next cycle.
- STRETCH (3): per-bit counter cnt[i].
  - If cap[ch][i]=1, reload cnt[i] to STRETCH_CYC.
  - Else if cnt[i]≠0, decrement cnt[i].
  - LD[i] = (cnt[i]≠0). A 1-cycle pulse lights its LED for exactly STRETCH_CYC cycles.
  - Counters are zeroed on entry and on a channel change.
- SCAN (4): ch_sel is ignored. Display as LIVE for scan_idx.
  - scan_cnt counts 0..SCAN_CYC-1. At terminal count, scan_idx increments, wrapping N_CH-1→0.
  - On entry, scan_idx=0 and scan_cnt=0.
  - With N_CH=1, scan_idx stays 0.
- Codes 5–7 behave as LIVE.
- rst asserted mid-operation: all state returns to reset values immediately (async). First valid LD is 2 cycles after deassertion.
- Widths: counter widths are $clog2(STRETCH_CYC+1) and $clog2(SCAN_CYC). No arithmetic overflow is possible.

Decomposition:
- Package debug_led_pkg:
  - typedef enum logic [2:0] led_mode_t {LIVE, HOLD, STICKY, STRETCH, SCAN}
  - mode-entry helper constants
- Sub-module bit_stretcher: parameters W and STRETCH_CYC; inputs clk, rst, clr, din[W]; output dout[W]. Generate one counter per bit. Instantiated once, with clr driven by STRETCH-mode entry or a channel change.
- Top module: capture reg, channel mux, mode FSM (previous-mode register for entry detection), sticky/hold regs, scan timer, output reg.

Test Plan (bench uses N_CH=4, W=8, STRETCH_CYC=4, SCAN_CYC=5):
- Reset/LIVE: assert rst, check LD=0 and ld_ch=0. Release, set mode=0, ch_sel=2, ch_data channel 2=0xA5 → LD=0xA5 two cycles later. Change ch_sel to 3 (channel 3=0x3C) → LD=0x3C next-but-one cycle.
- HOLD: LIVE with channel 1=0x11, switch mode=1, then change channel 1 to 0xFF and ch_sel to 0 → LD stays 0x11 and ld_ch stays 1 indefinitely.
- STICKY/clear: mode=2, ch_sel=0, pulse bit0, then bit7, one cycle each → LD=0x81. Assert clear together with a bit3 pulse → LD=0x00, then bit3 is not latched. The next bit3 pulse → LD=0x08.
- STRETCH: mode=3, 1-cycle pulse 0x01 → LD[0] high for exactly 4 cycles. A second pulse arriving 2 cycles in → LD[0] stays high 4 cycles past the second pulse.
- SCAN wrap: mode=4, channels=0x10,0x20,0x30,0x40 → ld_ch sequence 0,1,2,3,0 with 5 cycles per step; LD tracks each channel. ch_sel toggling has no effect.
- Edge cases: ch_sel=3 with N_CH=3 instance → channel 0 displayed. mode=6 → LIVE behaviour. Async rst mid-SCAN → LD=0 and ld_ch=0 immediately without a clock edge.

Source files
------------

// File: rtl/debug_led_pkg.sv
// rtl/debug_led_pkg.sv - mode encoding and shared helpers for the debug LED monitor
package debug_led_pkg;

  typedef enum logic [2:0] {
    LIVE    = 3'd0,
    HOLD    = 3'd1,
    STICKY  = 3'd2,
    STRETCH = 3'd3,
    SCAN    = 3'd4
  } led_mode_t;

  localparam logic [2:0] MODE_MAX = 3'd4;

  function automatic int clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

  // Unused codes fold onto LIVE so they never look like a distinct mode.
  function automatic led_mode_t decode_mode(input logic [2:0] m);
    return (m > MODE_MAX) ? LIVE : led_mode_t'(m);
  endfunction

  function automatic logic mode_entry(input led_mode_t cur, input led_mode_t prev,
                                      input led_mode_t target);
    return (cur == target) && (prev != target);
  endfunction

endpackage

// File: rtl/debug_led_monitor_stretch.sv
// rtl/debug_led_monitor_stretch.sv - per-bit pulse stretcher, reload on high, count down to zero
module bit_stretcher #(
  parameter int W           = 8,
  parameter int STRETCH_CYC = 10_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int SW = $clog2(STRETCH_CYC + 1);
  localparam logic [SW-1:0] RELOAD = SW'(STRETCH_CYC);

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_bit
      logic [SW-1:0] cnt;
      logic [SW-1:0] cnt_n;

      always_comb begin
        cnt_n = cnt;
        if (clr)
          cnt_n = '0;
        else if (din[i])
          cnt_n = RELOAD;
        else if (cnt != '0)
          cnt_n = cnt - SW'(1);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_n;
      end

      // Looking at the next count keeps stretch latency equal to live latency.
      assign dout[i] = (cnt_n != '0);
    end
  endgenerate

endmodule

// File: rtl/debug_led_monitor.sv
// rtl/debug_led_monitor.sv - multi-channel debug LED driver with live/hold/sticky/stretch/scan modes
module debug_led_monitor
  import debug_led_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int W           = 8,
  parameter int STRETCH_CYC = 10_000_000,
  parameter int SCAN_CYC    = 100_000_000,
  localparam int CW         = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] ch_data,
  input  logic [2:0]        mode,
  input  logic [CW-1:0]     ch_sel,
  input  logic              clear,
  output logic [W-1:0]      LD,
  output logic [CW-1:0]     ld_ch
);

  localparam int SCW = clog2_min1(SCAN_CYC);
  localparam logic [CW:0]    N_CH_L    = (CW + 1)'(N_CH);
  localparam logic [CW-1:0]  LAST_CH   = CW'(N_CH - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYC - 1);

  logic [N_CH*W-1:0] cap;
  logic              clear_q;
  led_mode_t         mode_q;
  logic [CW-1:0]     ch_q;
  logic [W-1:0]      hold_reg, acc;
  logic [CW-1:0]     hold_ch;
  logic [SCW-1:0]    scan_cnt;
  logic [CW-1:0]     scan_idx;

  led_mode_t         mode_n;
  logic [CW-1:0]     sel_ch, disp_ch, hold_ch_n, ld_ch_n, scan_idx_n;
  logic [SCW-1:0]    scan_cnt_n;
  logic [W-1:0]      live, acc_n, hold_reg_n, ld_n, str_dout;
  logic              ch_change, str_clr;
  logic [W-1:0]      cap_ch [2**CW];

  genvar k;
  generate
    for (k = 0; k < 2**CW; k++) begin : g_ch
      if (k < N_CH) begin : g_real
        assign cap_ch[k] = cap[k*W +: W];
      end else begin : g_pad
        assign cap_ch[k] = '0;
      end
    end
  endgenerate

  assign mode_n    = decode_mode(mode);
  assign sel_ch    = ({1'b0, ch_sel} < N_CH_L) ? ch_sel : '0;
  assign ch_change = (sel_ch != ch_q);

  // Scan timer; the display follows the post-update index so every dwell is SCAN_CYC long.
  always_comb begin
    scan_cnt_n = scan_cnt;
    scan_idx_n = scan_idx;
    if (mode_n == SCAN) begin
      if (mode_entry(mode_n, mode_q, SCAN)) begin
        scan_cnt_n = '0;
        scan_idx_n = '0;
      end else if (scan_cnt == SCAN_LAST) begin
        scan_cnt_n = '0;
        scan_idx_n = (scan_idx == LAST_CH) ? '0 : scan_idx + CW'(1);
      end else begin
        scan_cnt_n = scan_cnt + SCW'(1);
      end
    end
  end

  assign disp_ch = (mode_n == SCAN) ? scan_idx_n : sel_ch;
  assign live    = cap_ch[disp_ch];
  assign str_clr = mode_entry(mode_n, mode_q, STRETCH) || ch_change;

  bit_stretcher #(
    .W           (W),
    .STRETCH_CYC (STRETCH_CYC)
  ) u_stretch (
    .clk  (clk),
    .rst  (rst),
    .clr  (str_clr),
    .din  (live),
    .dout (str_dout)
  );

  always_comb begin
    acc_n      = acc;
    hold_reg_n = hold_reg;
    hold_ch_n  = hold_ch;
    ld_n       = live;
    ld_ch_n    = disp_ch;
    case (mode_n)
      HOLD: begin
        if (mode_entry(mode_n, mode_q, HOLD)) begin
          hold_reg_n = live;
          hold_ch_n  = sel_ch;
        end
        ld_n    = hold_reg_n;
        ld_ch_n = hold_ch_n;
      end
      STICKY: begin
        // clear_q travels with cap, so a clear beats the sample captured alongside it.
        if (mode_entry(mode_n, mode_q, STICKY) || ch_change || clear_q)
          acc_n = '0;
        else
          acc_n = acc | live;
        ld_n = acc_n;
      end
      STRETCH: ld_n = str_dout;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap      <= '0;
      clear_q  <= 1'b0;
      mode_q   <= LIVE;
      ch_q     <= '0;
      hold_reg <= '0;
      hold_ch  <= '0;
      acc      <= '0;
      scan_cnt <= '0;
      scan_idx <= '0;
      LD       <= '0;
      ld_ch    <= '0;
    end else begin
      cap      <= ch_data;
      clear_q  <= clear;
      mode_q   <= mode_n;
      ch_q     <= sel_ch;
      hold_reg <= hold_reg_n;
      hold_ch  <= hold_ch_n;
      acc      <= acc_n;
      scan_cnt <= scan_cnt_n;
      scan_idx <= scan_idx_n;
      LD       <= ld_n;
      ld_ch    <= ld_ch_n;
    end
  end

endmodule
